// File: rtl/uart_transmitter.sv
// 8N1/8N2 UART transmitter fed by a valid/ready byte stream; idle-high line, all outputs registered.
// Define UART_TRANSMITTER_HOLD_BUFFER_EN to add a one-entry holding register for gapless back-to-back frames.
module uart_transmitter #(
  parameter int BAUD_RATE       = 9600,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int STOP_BITS       = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       uart,
  output logic       busy
);

  localparam int DIVIDER = (CLOCK_FREQUENCY + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CNT_W   = $clog2(DIVIDER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVIDER - 1);
  localparam logic             STOP_LAST = (STOP_BITS == 2);

`ifdef UART_TRANSMITTER_HOLD_BUFFER_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  generate
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
      $error("uart_transmitter: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       bit_idx_reg, bit_idx_next;
  logic             stop_idx_reg, stop_idx_next;
  logic [7:0]       shift_reg, shift_next;
  logic [7:0]       hold_reg, hold_next;
  logic             hold_full_reg, hold_full_next;
  logic             uart_reg, uart_next;
  logic             busy_reg, busy_next;
  logic             ready_reg, ready_next;

  logic accept;
  logic bit_tick;
  logic take_direct;

  assign accept   = valid && ready_reg;
  assign bit_tick = (cnt_reg == CNT_LAST);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      cnt_reg       <= '0;
      bit_idx_reg   <= '0;
      stop_idx_reg  <= 1'b0;
      shift_reg     <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
      uart_reg      <= 1'b1;
      busy_reg      <= 1'b0;
      ready_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      bit_idx_reg   <= bit_idx_next;
      stop_idx_reg  <= stop_idx_next;
      shift_reg     <= shift_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
      uart_reg      <= uart_next;
      busy_reg      <= busy_next;
      ready_reg     <= ready_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_idx_next   = bit_idx_reg;
    stop_idx_next  = stop_idx_reg;
    shift_next     = shift_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    take_direct    = 1'b0;

    if (state_reg != ST_IDLE) begin
      cnt_next = bit_tick ? '0 : cnt_reg + CNT_W'(1);
    end

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          take_direct = 1'b1;
          shift_next  = data;
          cnt_next    = '0;
          state_next  = ST_START;
        end
      end
      ST_START: begin
        if (bit_tick) begin
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (bit_tick) begin
          if (bit_idx_reg == 3'd7) begin
            stop_idx_next = 1'b0;
            state_next    = ST_STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end
      end
      ST_STOP: begin
        if (bit_tick) begin
          if (stop_idx_reg == STOP_LAST) begin
            // End of frame: chain straight into the next start bit if a byte is waiting.
            if (HOLD_EN && hold_full_reg) begin
              shift_next     = hold_reg;
              hold_full_next = 1'b0;
              state_next     = ST_START;
            end else if (HOLD_EN && accept) begin
              take_direct = 1'b1;
              shift_next  = data;
              state_next  = ST_START;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            stop_idx_next = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (HOLD_EN && accept && !take_direct) begin
      hold_next      = data;
      hold_full_next = 1'b1;
    end
  end

  always_comb begin
    busy_next  = (state_next != ST_IDLE);
    ready_next = HOLD_EN ? !hold_full_next : (state_next == ST_IDLE);
    case (state_next)
      ST_START: uart_next = 1'b0;
      ST_DATA:  uart_next = shift_next[0];
      default:  uart_next = 1'b1;
    endcase
  end

  assign uart  = uart_reg;
  assign busy  = busy_reg;
  assign ready = ready_reg;

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with DIVIDER = 10; dut1 uses one stop bit, dut2 uses two.
module tb_uart_transmitter;

  localparam int MAXC = 320;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] data1 = 8'h00, data2 = 8'h00;
  logic       valid1 = 1'b0, valid2 = 1'b0;
  logic       ready1, uart1, busy1;
  logic       ready2, uart2, busy2;

  int checks = 0;
  int failures = 0;

  logic rec_uart [0:MAXC-1];
  logic rec_busy [0:MAXC-1];
  logic rec_ready[0:MAXC-1];
  logic exp_uart [0:MAXC-1];
  logic exp_busy [0:MAXC-1];
  logic exp_ready[0:MAXC-1];
  int   acc_idx[$];

  logic [7:0] qb[$];
  int         qa[$];
  int         qs[$];
  int         ql[$];

  always #5 clock = ~clock;

  uart_transmitter #(.BAUD_RATE(100000), .CLOCK_FREQUENCY(1000000), .STOP_BITS(1)) dut1 (
    .clock(clock), .reset(reset), .data(data1), .valid(valid1),
    .ready(ready1), .uart(uart1), .busy(busy1)
  );

  uart_transmitter #(.BAUD_RATE(100000), .CLOCK_FREQUENCY(1000000), .STOP_BITS(2)) dut2 (
    .clock(clock), .reset(reset), .data(data2), .valid(valid2),
    .ready(ready2), .uart(uart2), .busy(busy2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic logic get_uart(input int sel);
    return (sel == 2) ? uart2 : uart1;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 2) ? busy2 : busy1;
  endfunction

  function automatic logic get_ready(input int sel);
    return (sel == 2) ? ready2 : ready1;
  endfunction

  task automatic set_in(input int sel, input logic [7:0] d, input logic v);
    if (sel == 2) begin
      data2  = d;
      valid2 = v;
    end else begin
      data1  = d;
      valid1 = v;
    end
  endtask

  // Line value k cycles into a frame: start bit, data LSB first, then stop bits.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    int bit_n;
    bit_n = k / 10;
    if (bit_n == 0) return 1'b0;
    if (bit_n <= 8) return b[bit_n-1];
    return 1'b1;
  endfunction

  task automatic build_exp(input int stops, input logic [7:0] bytes[$], input int starts[$],
                           input int lows[$], input int ncyc);
    int flen;
    flen = (9 + stops) * 10;
    for (int c = 0; c <= ncyc; c++) begin
      exp_uart[c]  = 1'b1;
      exp_busy[c]  = 1'b0;
      exp_ready[c] = 1'b1;
    end
    for (int j = 0; j < starts.size(); j++) begin
      for (int k = 0; k < flen; k++) begin
        if (starts[j] + k <= ncyc) begin
          exp_uart[starts[j]+k] = frame_bit(bytes[j], k);
          exp_busy[starts[j]+k] = 1'b1;
        end
      end
    end
    for (int p = 0; p + 1 < lows.size(); p += 2) begin
      for (int c = lows[p]; c <= lows[p+1]; c++) exp_ready[c] = 1'b0;
    end
  endtask

  // Offers bytes with a handshake-driven source; records outputs at every falling edge.
  task automatic run_stream(input int sel, input logic [7:0] bytes[$], input int ncyc);
    int   idx;
    logic v;
    logic will;
    acc_idx = {};
    idx = 0;
    @(negedge clock);
    v = (bytes.size() > 0);
    set_in(sel, v ? bytes[0] : 8'h00, v);
    will = v && get_ready(sel);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clock);
      rec_uart[c]  = get_uart(sel);
      rec_busy[c]  = get_busy(sel);
      rec_ready[c] = get_ready(sel);
      if (will) begin
        acc_idx.push_back(c - 1);
        idx++;
        v = (idx < bytes.size());
        set_in(sel, v ? bytes[idx] : 8'h00, v);
      end
      will = v && get_ready(sel);
    end
    set_in(sel, 8'h00, 1'b0);
  endtask

  task automatic scenario(input string tag, input int sel, input int stops, input int ncyc);
    int mu, mb, mr, nbusy;
    build_exp(stops, qb, qs, ql, ncyc);
    run_stream(sel, qb, ncyc);
    mu = 0; mb = 0; mr = 0; nbusy = 0;
    for (int c = 1; c <= ncyc; c++) begin
      if (rec_uart[c]  !== exp_uart[c])  mu++;
      if (rec_busy[c]  !== exp_busy[c])  mb++;
      if (rec_ready[c] !== exp_ready[c]) mr++;
      if (rec_busy[c] === 1'b1) nbusy++;
    end
    check({tag, "_uart_bad_cycles"}, mu, 0);
    check({tag, "_busy_bad_cycles"}, mb, 0);
    check({tag, "_ready_bad_cycles"}, mr, 0);
    check({tag, "_busy_total"}, nbusy, qs.size() * (9 + stops) * 10);
    check({tag, "_accepts"}, acc_idx.size(), qa.size());
    for (int j = 0; j < qa.size() && j < acc_idx.size(); j++)
      check($sformatf("%s_accept%0d_cycle", tag, j), acc_idx[j], qa[j]);
    $display("scenario %s: uart_bad=%0d busy_bad=%0d ready_bad=%0d busy_cycles=%0d accepts=%0d",
             tag, mu, mb, mr, nbusy, acc_idx.size());
  endtask

  initial begin
    // Reset then idle
    repeat (5) @(negedge clock);
    check("rst_uart", uart1, 1'b1);
    check("rst_ready", ready1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    check("rst_ready2", ready2, 1'b0);
    reset = 1'b1;
    #1;
    check("rel_ready_before_edge", ready1, 1'b0);
    @(negedge clock);
    check("rel_ready_first_edge", ready1, 1'b1);
    check("rel_ready2_first_edge", ready2, 1'b1);
    check("rel_uart_idle", uart1, 1'b1);
    $display("reset: uart=%0d ready=%0d busy=%0d", uart1, ready1, busy1);

    // Single 0x55, one stop bit
    qb = {}; qa = {}; qs = {}; ql = {};
    qb.push_back(8'h55); qa.push_back(0); qs.push_back(1);
`ifdef UART_TRANSMITTER_HOLD_BUFFER_EN
`else
    ql.push_back(1); ql.push_back(100);
`endif
    scenario("byte55", 1, 1, 110);

    // Single 0xA3, two stop bits
    qb = {}; qa = {}; qs = {}; ql = {};
    qb.push_back(8'hA3); qa.push_back(0); qs.push_back(1);
`ifdef UART_TRANSMITTER_HOLD_BUFFER_EN
`else
    ql.push_back(1); ql.push_back(110);
`endif
    scenario("byteA3_2stop", 2, 2, 120);

    // Back-to-back 0x00 then 0xFF with valid held
    qb = {}; qa = {}; qs = {}; ql = {};
    qb.push_back(8'h00); qb.push_back(8'hFF);
`ifdef UART_TRANSMITTER_HOLD_BUFFER_EN
    qa.push_back(0); qa.push_back(1);
    qs.push_back(1); qs.push_back(101);
    ql.push_back(2); ql.push_back(100);
`else
    qa.push_back(0); qa.push_back(101);
    qs.push_back(1); qs.push_back(102);
    ql.push_back(1); ql.push_back(100); ql.push_back(102); ql.push_back(201);
`endif
    scenario("b2b", 1, 1, 215);

    // Reset during data bit 3 of 0x0F
    @(negedge clock);
    set_in(1, 8'h0F, 1'b1);
    @(negedge clock);
    set_in(1, 8'h00, 1'b0);
    repeat (43) @(negedge clock);
    check("midrst_busy_before", busy1, 1'b1);
    check("midrst_bit3_before", uart1, 1'b1);
    #2 reset = 1'b0;
    #1;
    check("midrst_uart", uart1, 1'b1);
    check("midrst_busy", busy1, 1'b0);
    check("midrst_ready", ready1, 1'b0);
    $display("midframe reset: uart=%0d busy=%0d ready=%0d", uart1, busy1, ready1);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_rel_ready", ready1, 1'b1);
    check("midrst_rel_busy", busy1, 1'b0);
    qb = {}; qa = {}; qs = {}; ql = {};
    qb.push_back(8'h81); qa.push_back(0); qs.push_back(1);
`ifdef UART_TRANSMITTER_HOLD_BUFFER_EN
`else
    ql.push_back(1); ql.push_back(100);
`endif
    scenario("after_rst_81", 1, 1, 110);

    // Back-pressure: three bytes offered during the first frame
    qb = {}; qa = {}; qs = {}; ql = {};
    qb.push_back(8'h3C); qb.push_back(8'hC5); qb.push_back(8'h96);
`ifdef UART_TRANSMITTER_HOLD_BUFFER_EN
    qa.push_back(0); qa.push_back(1); qa.push_back(101);
    qs.push_back(1); qs.push_back(101); qs.push_back(201);
    ql.push_back(2); ql.push_back(100); ql.push_back(102); ql.push_back(200);
`else
    qa.push_back(0); qa.push_back(101); qa.push_back(202);
    qs.push_back(1); qs.push_back(102); qs.push_back(203);
    ql.push_back(1); ql.push_back(100); ql.push_back(102); ql.push_back(201);
    ql.push_back(203); ql.push_back(302);
`endif
    scenario("backpressure", 1, 1, 310);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Serialises bytes from a valid/ready stream onto an asynchronous UART line as 8N1 or 8N2 frames: start bit, eight data bits LSB first, no parity, then one or two stop bits. It is the transmit companion to the board's UART receive path and sits between the host-bound result stream and the FPGA's UART TX pin.

## Interface

Parameters:
- `BAUD_RATE`, 9600, line bit rate in bits/s.
- `CLOCK_FREQUENCY`, 100000000, `clock` frequency in Hz.
- `STOP_BITS`, 1, number of stop bits per frame; legal values are 1 or 2, and any other value is an elaboration error.

Ports:
- `clock` input 1: single clock domain for all logic.
- `reset` input 1: reset, asynchronous and active-low.
- `data` input 8: byte to transmit; sampled on accept.
- `valid` input 1: `data` is valid.
- `ready` output 1: the block can accept a byte this cycle.
- `uart` output 1: serial line, idle high.
- `busy` output 1: a frame is in progress on `uart`.

## Operation

- Bit period: `DIVIDER = (CLOCK_FREQUENCY + BAUD_RATE/2) / BAUD_RATE`, rounded to nearest; with the defaults this is 10417. The bit counter width is `$clog2(DIVIDER+1)`.
- Accept: a byte is accepted on a rising edge where `valid && ready`. `data` is captured at that edge. The source must hold `data` and `valid` until accepted.
- States:
  - IDLE → START on accept.
  - START → DATA after `DIVIDER` cycles.
  - DATA → STOP after 8 bit periods; bit index runs 0 to 7.
  - STOP → IDLE after `STOP_BITS` bit periods, or STOP → START when the next byte is already available (see Configuration).
- `uart` value per state: IDLE = 1, START = 0, DATA = shift register bit 0 (shift right once per bit period), STOP = 1.
- All outputs are registered. `uart` has no combinational path from the inputs.
- `busy` is 1 in START, DATA and STOP, and 0 in IDLE.
- `valid` is ignored while `ready` = 0. Changing `data` while `valid && !ready` has no effect on the frame currently on the line.

## Timing

- Reset values, applied asynchronously when `reset` is 0: `uart` = 1, `ready` = 0, `busy` = 0, state = IDLE, counters = 0, buffer empty.
- `ready` rises on the first rising edge after `reset` deasserts.
- Latency: the start bit appears on `uart` at the rising edge that accepts the byte. `uart` therefore goes low in the cycle following acceptance.
- Every bit, including each stop bit, is held for exactly `DIVIDER` cycles.
- A frame lasts exactly `(9 + STOP_BITS) * DIVIDER` cycles.
- Without the hold buffer:
  - `ready` = 1 only in IDLE. It drops in the cycle after the accept.
  - `ready` returns to 1 in the cycle after the last stop-bit cycle.
  - The minimum line gap between consecutive frames is therefore 1 idle-high cycle.
- Reset asserted mid-frame: `uart` returns to 1 immediately. The partial frame is discarded and not resumed after reset.

## Configuration

- `UART_TRANSMITTER_HOLD_BUFFER_EN` defined: adds a one-entry holding register.
  - `ready` = 1 whenever the holding register is empty, including during a frame.
  - A byte accepted mid-frame is stored in the holding register.
  - At the end of the last stop-bit period, a full holding register moves into the shift register and START begins on the very next cycle, with zero idle cycles between frames. The holding register empties and `ready` rises again one cycle later.
  - An accept that occurs on the last stop-bit cycle while the holding register is empty loads the shift register directly, with no gap.
- Macro not defined: no holding register; behaviour is exactly as described under Timing.

## Test plan

Use `CLOCK_FREQUENCY` = 1000000 and `BAUD_RATE` = 100000, so `DIVIDER` = 10, unless a scenario says otherwise.

- Reset then idle: hold `reset` = 0 for 5 cycles and release. Required: `uart` = 1, `ready` = 0 and `busy` = 0 during reset; `ready` = 1 on the first edge after release.
- Single byte 0x55, `STOP_BITS` = 1: `uart` reads 0,1,0,1,0,1,0,1,0,1, each bit held 10 cycles. `busy` is high for exactly 100 cycles. `ready` = 0 throughout the frame when the buffer is compiled out.
- Single byte 0xA3, `STOP_BITS` = 2: data bits are 1,1,0,0,0,1,0,1. The frame is 110 cycles, ending in 20 high cycles.
- Back-to-back 0x00 then 0xFF, `valid` held high:
  - Without the macro: exactly 1 idle-high cycle between the two frames.
  - With the macro: zero gap, and the second byte is accepted in cycle 1 of the first frame.
- `reset` = 0 during data bit 3 of 0x0F: `uart` = 1 in the same cycle. After release, the next accepted byte 0x81 is sent as a complete, correct frame.
- Back-pressure, with the macro: offer 3 bytes during frame 1. Required: bytes 2 and 3 are accepted in order, `ready` stays low while the holding register is full, and all three frames are transmitted in order.
